// File: rtl/apb_pkg.sv
// Shared APB fabric definitions: FSM state encoding and default bus widths.
package apb_pkg;

  localparam int unsigned ADDR_W_DEF = 5;
  localparam int unsigned DATA_W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_e;

endpackage

// File: rtl/apb_rr_pick2.sv
// Two-way round-robin pick: a lone request wins, a tie goes to the requester named by prio.
module apb_rr_pick2 (
  input  logic req0,
  input  logic req1,
  input  logic prio,
  output logic valid,
  output logic winner
);

  assign valid  = req0 | req1;
  assign winner = (req0 && req1) ? prio : req1;

endmodule

// File: rtl/apb_arbiter2.sv
// Two-requester APB arbiter: round-robin grant, each transfer re-issued downstream
// as a registered SETUP/ACCESS pair, with an optional hung-completer timeout.
module apb_arbiter2
  import apb_pkg::*;
#(
  parameter int unsigned       ADDR_W       = ADDR_W_DEF,
  parameter int unsigned       DATA_W       = DATA_W_DEF,
  parameter int unsigned       TIMEOUT      = 0,
  parameter logic [DATA_W-1:0] TIMEOUT_DATA = DATA_W'(8'hFF)
) (
  input  logic              PCLK,
  input  logic              PRESET,
  input  logic              m0_PSEL,
  input  logic              m0_PENABLE,
  input  logic [ADDR_W-1:0] m0_PADDR,
  input  logic              m0_PWRITE,
  input  logic [DATA_W-1:0] m0_PWDATA,
  output logic [DATA_W-1:0] m0_PRDATA,
  output logic              m0_PREADY,
  input  logic              m1_PSEL,
  input  logic              m1_PENABLE,
  input  logic [ADDR_W-1:0] m1_PADDR,
  input  logic              m1_PWRITE,
  input  logic [DATA_W-1:0] m1_PWDATA,
  output logic [DATA_W-1:0] m1_PRDATA,
  output logic              m1_PREADY,
  output logic              PSEL,
  output logic              PENABLE,
  output logic              PWRITE,
  output logic [ADDR_W-1:0] PADDR,
  output logic [DATA_W-1:0] PWDATA,
  input  logic [DATA_W-1:0] PRDATA,
  input  logic              PREADY,
  output logic              grant
);

  localparam int unsigned CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  apb_state_e        state, state_n;
  logic [CNT_W-1:0]  cnt, cnt_n;
  logic              prio, prio_n;
  logic              grant_n;
  logic              psel_n, penable_n, pwrite_n;
  logic [ADDR_W-1:0] paddr_n;
  logic [DATA_W-1:0] pwdata_n;

  logic              pick_valid, pick_winner;
  logic              timeout_hit_c, done_c;
  logic [DATA_W-1:0] rdata_c;

  // Requester PENABLE is observed for protocol completeness only.
  logic unused_penable;
  assign unused_penable = m0_PENABLE ^ m1_PENABLE;

  apb_rr_pick2 u_pick (
    .req0   (m0_PSEL),
    .req1   (m1_PSEL),
    .prio   (prio),
    .valid  (pick_valid),
    .winner (pick_winner)
  );

  // A real PREADY in the timeout cycle wins and returns real data.
  assign timeout_hit_c = (TIMEOUT > 0) && (cnt == CNT_W'(TIMEOUT));
  assign done_c        = (state == ACCESS) && (PREADY || timeout_hit_c);
  assign rdata_c       = PREADY ? PRDATA : TIMEOUT_DATA;

  // Completion strobe and read data routed back to the owner only.
  always_comb begin
    m0_PREADY = 1'b0;
    m1_PREADY = 1'b0;
    m0_PRDATA = '0;
    m1_PRDATA = '0;
    if (done_c) begin
      if (grant) begin
        m1_PREADY = 1'b1;
        m1_PRDATA = rdata_c;
      end else begin
        m0_PREADY = 1'b1;
        m0_PRDATA = rdata_c;
      end
    end
  end

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    prio_n   = prio;
    grant_n  = grant;
    paddr_n  = PADDR;
    pwdata_n = PWDATA;
    pwrite_n = PWRITE;
    case (state)
      IDLE: begin
        if (pick_valid) begin
          state_n  = SETUP;
          grant_n  = pick_winner;
          paddr_n  = pick_winner ? m1_PADDR  : m0_PADDR;
          pwdata_n = pick_winner ? m1_PWDATA : m0_PWDATA;
          pwrite_n = pick_winner ? m1_PWRITE : m0_PWRITE;
        end
      end
      SETUP: begin
        state_n = ACCESS;
        cnt_n   = '0;
      end
      ACCESS: begin
        // Always drop back to IDLE so a still-high PSEL is not re-granted.
        if (done_c) begin
          state_n = IDLE;
          prio_n  = ~grant;
        end else if (TIMEOUT > 0) begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      default: state_n = IDLE;
    endcase
    psel_n    = (state_n != IDLE);
    penable_n = (state_n == ACCESS);
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state   <= IDLE;
      cnt     <= '0;
      prio    <= 1'b0;
      grant   <= 1'b0;
      PSEL    <= 1'b0;
      PENABLE <= 1'b0;
      PWRITE  <= 1'b0;
      PADDR   <= '0;
      PWDATA  <= '0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      prio    <= prio_n;
      grant   <= grant_n;
      PSEL    <= psel_n;
      PENABLE <= penable_n;
      PWRITE  <= pwrite_n;
      PADDR   <= paddr_n;
      PWDATA  <= pwdata_n;
    end
  end

endmodule

// File: tb/tb_apb_arbiter2.sv
// Scoreboard bench for apb_arbiter2: requester tasks push expectations, completions pop and compare.
module tb_apb_arbiter2;

  logic       PCLK, PRESET;
  logic       m0_PSEL, m0_PENABLE, m0_PWRITE;
  logic [4:0] m0_PADDR;
  logic [7:0] m0_PWDATA, m0_PRDATA;
  logic       m0_PREADY;
  logic       m1_PSEL, m1_PENABLE, m1_PWRITE;
  logic [4:0] m1_PADDR;
  logic [7:0] m1_PWDATA, m1_PRDATA;
  logic       m1_PREADY;
  logic       PSEL, PENABLE, PWRITE;
  logic [4:0] PADDR;
  logic [7:0] PWDATA, PRDATA;
  logic       PREADY;
  logic       grant;

  int         n_cmp, n_err;
  int         wait_cfg, acc_cnt, m0_done;
  logic [7:0] rdata_cfg;
  bit         stuck;

  typedef struct {
    logic [4:0] addr;
    logic       write;
    logic [7:0] wdata;
    logic [7:0] rdata;
  } exp_t;

  exp_t q0[$], q1[$];
  int   done_ids[$];

  apb_arbiter2 #(.ADDR_W(5), .DATA_W(8), .TIMEOUT(4), .TIMEOUT_DATA(8'hFF)) dut (
    .PCLK(PCLK), .PRESET(PRESET),
    .m0_PSEL(m0_PSEL), .m0_PENABLE(m0_PENABLE), .m0_PADDR(m0_PADDR), .m0_PWRITE(m0_PWRITE),
    .m0_PWDATA(m0_PWDATA), .m0_PRDATA(m0_PRDATA), .m0_PREADY(m0_PREADY),
    .m1_PSEL(m1_PSEL), .m1_PENABLE(m1_PENABLE), .m1_PADDR(m1_PADDR), .m1_PWRITE(m1_PWRITE),
    .m1_PWDATA(m1_PWDATA), .m1_PRDATA(m1_PRDATA), .m1_PREADY(m1_PREADY),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
    .PRDATA(PRDATA), .PREADY(PREADY), .grant(grant)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  // Completer model: wait_cfg wait states per access, or never ready when stuck.
  assign PREADY = !stuck && (acc_cnt >= wait_cfg);
  assign PRDATA = rdata_cfg;
  always @(posedge PCLK) begin
    if (PSEL && PENABLE && !PREADY) acc_cnt <= acc_cnt + 1;
    else acc_cnt <= 0;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int take_done();
    if (done_ids.size() == 0) return -1;
    return done_ids.pop_front();
  endfunction

  // One requester transfer; called at posedge+1, returns at posedge+1 after completion.
  task automatic issue(input int m, input logic [4:0] a, input logic w,
                       input logic [7:0] wd, input logic [7:0] rd);
    exp_t e;
    bit   seen;
    e.addr = a; e.write = w; e.wdata = wd; e.rdata = rd;
    if (m == 0) begin
      q0.push_back(e);
      m0_PSEL = 1'b1; m0_PENABLE = 1'b0; m0_PADDR = a; m0_PWRITE = w; m0_PWDATA = wd;
    end else begin
      q1.push_back(e);
      m1_PSEL = 1'b1; m1_PENABLE = 1'b0; m1_PADDR = a; m1_PWRITE = w; m1_PWDATA = wd;
    end
    seen = 1'b0;
    for (int n = 0; n < 60 && !seen; n++) begin
      @(negedge PCLK);
      seen = (m == 0) ? m0_PREADY : m1_PREADY;
      if (m == 0) m0_PENABLE = 1'b1; else m1_PENABLE = 1'b1;
    end
    e = (m == 0) ? q0.pop_front() : q1.pop_front();
    if (!seen) begin
      check($sformatf("ready_timeout_m%0d", m), 0, 1);
    end else begin
      check($sformatf("grant_m%0d", m), 32'(grant), 32'(m));
      check($sformatf("paddr_m%0d", m), 32'(PADDR), 32'(e.addr));
      check($sformatf("pwrite_m%0d", m), 32'(PWRITE), 32'(e.write));
      if (e.write)
        check($sformatf("pwdata_m%0d", m), 32'(PWDATA), 32'(e.wdata));
      else
        check($sformatf("prdata_m%0d", m), 32'((m == 0) ? m0_PRDATA : m1_PRDATA), 32'(e.rdata));
      check($sformatf("other_ready_m%0d", m), 32'((m == 0) ? m1_PREADY : m0_PREADY), 0);
      check($sformatf("other_prdata_m%0d", m), 32'((m == 0) ? m1_PRDATA : m0_PRDATA), 0);
      done_ids.push_back(m);
      if (m == 0) m0_done++;
      fork
        begin
          @(negedge PCLK);
          check("idle_after_done", 32'(PSEL), 0);
        end
      join_none
    end
    @(posedge PCLK); #1;
    if (m == 0) begin m0_PSEL = 1'b0; m0_PENABLE = 1'b0; end
    else begin m1_PSEL = 1'b0; m1_PENABLE = 1'b0; end
  endtask

  // Counts contiguous downstream ACCESS cycles up to and including the completion.
  task automatic count_access(output int cyc);
    bit started, fin;
    started = 1'b0; fin = 1'b0; cyc = 0;
    for (int k = 0; k < 60 && !fin; k++) begin
      @(negedge PCLK);
      if (PSEL && PENABLE) begin
        started = 1'b1;
        cyc++;
        if (m0_PREADY || m1_PREADY) fin = 1'b1;
      end else if (started) begin
        fin = 1'b1;
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge PCLK);
    #1;
  endtask

  initial begin
    int cyc, base, found;
    n_cmp = 0; n_err = 0; m0_done = 0;
    wait_cfg = 0; rdata_cfg = 8'h00; stuck = 1'b0;
    m0_PSEL = 0; m0_PENABLE = 0; m0_PADDR = 0; m0_PWRITE = 0; m0_PWDATA = 0;
    m1_PSEL = 0; m1_PENABLE = 0; m1_PADDR = 0; m1_PWRITE = 0; m1_PWDATA = 0;
    PRESET = 1'b1;

    @(posedge PCLK); @(negedge PCLK);
    check("rst_psel", 32'(PSEL), 0);
    check("rst_penable", 32'(PENABLE), 0);
    check("rst_grant", 32'(grant), 0);
    check("rst_paddr", 32'(PADDR), 0);
    check("rst_m0_ready", 32'(m0_PREADY), 0);
    @(posedge PCLK); #1;
    PRESET = 1'b0;
    idle(2);

    // Contention twice: prio alternates so m0 wins both rounds
    rdata_cfg = 8'h66;
    for (int r = 0; r < 2; r++) begin
      done_ids.delete();
      fork
        issue(0, 5'h01, 1'b1, 8'h10, 8'h00);
        issue(1, 5'h02, 1'b0, 8'h00, 8'h66);
      join
      check($sformatf("contention_first_r%0d", r), 32'(take_done()), 0);
      check($sformatf("contention_second_r%0d", r), 32'(take_done()), 1);
      idle(2);
    end

    // Single write with minimum latency
    fork
      issue(0, 5'h15, 1'b1, 8'hA5, 8'h00);
      begin
        @(negedge PCLK);
        check("sw_t0_psel", 32'(PSEL), 0);
        @(negedge PCLK);
        check("sw_setup_psel", 32'(PSEL), 1);
        check("sw_setup_penable", 32'(PENABLE), 0);
        check("sw_setup_ready", 32'(m0_PREADY), 0);
        @(negedge PCLK);
        check("sw_access_penable", 32'(PENABLE), 1);
        check("sw_access_ready", 32'(m0_PREADY), 1);
        check("sw_m1_ready", 32'(m1_PREADY), 0);
        @(negedge PCLK);
        check("sw_after_ready", 32'(m0_PREADY), 0);
      end
    join
    idle(2);

    // Wait states: three not-ready ACCESS cycles then data
    wait_cfg = 3; rdata_cfg = 8'h5C;
    fork
      issue(1, 5'h03, 1'b0, 8'h00, 8'h5C);
      count_access(cyc);
    join
    check("wait_access_cycles", 32'(cyc), 4);
    wait_cfg = 0;
    idle(2);

    // Timeout: four counted ACCESS cycles, forced completion on the next
    stuck = 1'b1;
    fork
      issue(0, 5'h07, 1'b0, 8'h00, 8'hFF);
      count_access(cyc);
    join
    check("timeout_access_cycles", 32'(cyc), 5);
    stuck = 1'b0;
    idle(1);
    rdata_cfg = 8'h42;
    issue(0, 5'h08, 1'b0, 8'h00, 8'h42);
    idle(2);

    // Asynchronous reset in mid-ACCESS with m1 pending
    stuck = 1'b1; rdata_cfg = 8'hC3;
    m0_PSEL = 1'b1; m0_PADDR = 5'h1F; m0_PWRITE = 1'b1; m0_PWDATA = 8'h77;
    fork
      begin
        @(posedge PCLK); #1;
        issue(1, 5'h0A, 1'b0, 8'h00, 8'hC3);
      end
      begin
        found = 0;
        for (int k = 0; k < 10 && found == 0; k++) begin
          @(negedge PCLK);
          found = (PSEL && PENABLE) ? 1 : 0;
        end
        check("rst_mid_reached_access", 32'(found), 1);
        #2 PRESET = 1'b1;
        #1;
        check("rst_mid_psel", 32'(PSEL), 0);
        check("rst_mid_penable", 32'(PENABLE), 0);
        check("rst_mid_pwrite", 32'(PWRITE), 0);
        check("rst_mid_paddr", 32'(PADDR), 0);
        check("rst_mid_pwdata", 32'(PWDATA), 0);
        check("rst_mid_m0_ready", 32'(m0_PREADY), 0);
        m0_PSEL = 1'b0; m0_PWRITE = 1'b0;
        stuck = 1'b0;
        @(posedge PCLK); #1;
        PRESET = 1'b0;
      end
    join
    idle(2);

    // Starvation: m0 back-to-back, m1 must get in after at most one m0 transfer
    wait_cfg = 1; rdata_cfg = 8'h99;
    fork
      begin
        issue(0, 5'h11, 1'b1, 8'h01, 8'h00);
        issue(0, 5'h12, 1'b1, 8'h02, 8'h00);
        issue(0, 5'h13, 1'b1, 8'h03, 8'h00);
      end
      begin
        @(posedge PCLK); #1;
        base = m0_done;
        issue(1, 5'h1C, 1'b0, 8'h00, 8'h99);
        check("starve_m0_before_m1", 32'((m0_done - base) <= 1), 1);
      end
    join
    idle(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
